// File: rtl/game_pkg.sv
// Shared constants and state encoding for the card-game blocks.
// player_hand and the deck/display logic both import this package.
package game_pkg;

    localparam int BJ_LIMIT   = 21;
    localparam int ACE_RANK   = 1;
    localparam int FACE_VALUE = 10;
    localparam int RANK_W     = 4;
    localparam int TOTAL_W    = 5;
    localparam int COUNT_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ADD,
        ST_CHECK,
        ST_DONE
    } hand_state_t;

endpackage

// File: rtl/player_hand_if.sv
// Seat-side bundle between the game controller/deck and one player_hand.
// The controller/deck side uses the master modport; player_hand uses the slave modport.
interface player_hand_if;
    import game_pkg::*;

    logic                cardReady;
    logic                stand;
    logic                deckAck;
    logic [RANK_W-1:0]   deckCard;
    logic                deckReq;
    logic [TOTAL_W-1:0]  totalValue;
    logic [COUNT_W-1:0]  cardCount;
    logic                finish;
    logic                bust;
    logic                blackjack;
    logic                badCard;

    modport master (
        output cardReady, stand, deckAck, deckCard,
        input  deckReq, totalValue, cardCount, finish, bust, blackjack, badCard
    );

    modport slave (
        input  cardReady, stand, deckAck, deckCard,
        output deckReq, totalValue, cardCount, finish, bust, blackjack, badCard
    );

endinterface

// File: rtl/card_value_lut.sv
// Combinational card rank to blackjack value decode.
// Aces report 1 here; the 11-or-1 choice depends on the hand and is made by the caller.
module card_value_lut
    import game_pkg::*;
(
    input  logic [RANK_W-1:0]  i_rank,
    output logic [TOTAL_W-1:0] o_value,
    output logic               o_is_ace,
    output logic               o_invalid
);

    always_comb begin
        o_value   = '0;
        o_is_ace  = 1'b0;
        o_invalid = 1'b0;
        if (i_rank == '0 || i_rank > RANK_W'(13)) begin
            o_invalid = 1'b1;
        end else if (i_rank == RANK_W'(ACE_RANK)) begin
            o_is_ace = 1'b1;
            o_value  = TOTAL_W'(1);
        end else if (i_rank >= RANK_W'(11)) begin
            o_value = TOTAL_W'(FACE_VALUE);
        end else begin
            o_value = TOTAL_W'(i_rank);
        end
    end

endmodule

// File: rtl/player_hand.sv
// One seat's hand: fetches cards from the deck while allowed and closes on stand, bust or full hand.
//   state    | meaning
//   ST_IDLE  | waiting for cardReady or stand
//   ST_REQ   | deckReq high until deckAck, card latched on ack
//   ST_ADD   | add latched card value (ace soft when it fits)
//   ST_CHECK | soft-ace fix-up, then bust/blackjack/stand evaluation
//   ST_DONE  | hand closed until new_Game
module player_hand
    import game_pkg::*;
#(
    parameter int STAND_AT  = 17,
    parameter int MAX_CARDS = 5
) (
    input  logic          i_clock,
    input  logic          i_new_Game,
    player_hand_if.slave  hand
);

    hand_state_t        r_state, w_state;
    logic [RANK_W-1:0]  r_card, w_card;
    logic [TOTAL_W-1:0] r_total, w_total;
    logic [COUNT_W-1:0] r_count, w_count;
    logic               r_soft, w_soft;
    logic               r_bust, w_bust;
    logic               r_blackjack, w_blackjack;
    logic               r_bad, w_bad;

    logic [TOTAL_W-1:0] w_value;
    logic               w_is_ace;
    logic               w_invalid;
    logic [TOTAL_W:0]   w_ace_sum;
    logic [TOTAL_W-1:0] w_adj;

    card_value_lut u_lut (
        .i_rank    (r_card),
        .o_value   (w_value),
        .o_is_ace  (w_is_ace),
        .o_invalid (w_invalid)
    );

    always_ff @(posedge i_clock or posedge i_new_Game) begin
        if (i_new_Game) begin
            r_state     <= ST_IDLE;
            r_card      <= '0;
            r_total     <= '0;
            r_count     <= '0;
            r_soft      <= 1'b0;
            r_bust      <= 1'b0;
            r_blackjack <= 1'b0;
            r_bad       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_card      <= w_card;
            r_total     <= w_total;
            r_count     <= w_count;
            r_soft      <= w_soft;
            r_bust      <= w_bust;
            r_blackjack <= w_blackjack;
            r_bad       <= w_bad;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_card      = r_card;
        w_total     = r_total;
        w_count     = r_count;
        w_soft      = r_soft;
        w_bust      = r_bust;
        w_blackjack = r_blackjack;
        w_bad       = r_bad;
        w_ace_sum   = {1'b0, r_total} + (TOTAL_W+1)'(11);
        w_adj       = r_total;

        case (r_state)
            ST_IDLE: begin
                if (hand.stand)          w_state = ST_DONE;
                else if (hand.cardReady) w_state = ST_REQ;
            end
            ST_REQ: begin
                if (hand.deckAck) begin
                    w_card  = hand.deckCard;
                    w_state = ST_ADD;
                end
            end
            ST_ADD: begin
                if (w_invalid) begin
                    w_bad   = 1'b1;
                    w_state = ST_IDLE;
                end else begin
                    w_bad = 1'b0;
                    // An ace counts 11 only when that cannot bust; total <= 20 here so no wrap.
                    if (w_is_ace && w_ace_sum <= (TOTAL_W+1)'(BJ_LIMIT)) begin
                        w_total = w_ace_sum[TOTAL_W-1:0];
                        w_soft  = 1'b1;
                    end else begin
                        w_total = r_total + w_value;
                    end
                    w_count = r_count + COUNT_W'(1);
                    w_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (r_total > TOTAL_W'(BJ_LIMIT) && r_soft) begin
                    w_adj  = r_total - TOTAL_W'(10);
                    w_soft = 1'b0;
                end
                w_total = w_adj;
                if (w_adj > TOTAL_W'(BJ_LIMIT)) begin
                    w_bust  = 1'b1;
                    w_state = ST_DONE;
                end else if (w_adj == TOTAL_W'(BJ_LIMIT) && r_count == COUNT_W'(2)) begin
                    w_blackjack = 1'b1;
                    w_state     = ST_DONE;
                end else if (w_adj >= TOTAL_W'(STAND_AT) || r_count == COUNT_W'(MAX_CARDS)) begin
                    w_state = ST_DONE;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_DONE: w_state = ST_DONE;
            default: w_state = ST_IDLE;
        endcase
    end

    assign hand.deckReq    = (r_state == ST_REQ);
    assign hand.finish     = (r_state == ST_DONE);
    assign hand.totalValue = r_total;
    assign hand.cardCount  = r_count;
    assign hand.bust       = r_bust;
    assign hand.blackjack  = r_blackjack;
    assign hand.badCard    = r_bad;

endmodule

// File: tb/tb_player_hand.sv
// Bench for player_hand: plays scripted hands against a deck driver and scores each card's result.
module tb_player_hand;

    typedef struct packed {
        logic [4:0] tot;
        logic [2:0] cnt;
        logic       bad;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb[$];

    player_hand_if hif ();

    player_hand #(.STAND_AT(17), .MAX_CARDS(5)) dut (
        .i_clock    (clk),
        .i_new_Game (rst),
        .hand       (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        hif.cardReady = 1'b0;
        hif.stand     = 1'b0;
        hif.deckAck   = 1'b0;
        hif.deckCard  = 4'd0;
    endtask

    task automatic new_game();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for deckReq, answers after ack_wait cycles, then checks the hand after CHECK.
    task automatic deal(input logic [3:0] rank, input int ack_wait,
                        input logic [4:0] e_tot, input logic [2:0] e_cnt,
                        input logic e_bad, input logic drop_ready);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (hif.deckReq) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL deckReq_wait rank=%0d: deckReq=0 after 50 cycles, required 1", rank);
            return;
        end
        if (drop_ready) hif.cardReady = 1'b0;
        repeat (ack_wait) @(negedge clk);
        hif.deckAck  = 1'b1;
        hif.deckCard = rank;
        sb.push_back('{tot: e_tot, cnt: e_cnt, bad: e_bad});
        @(negedge clk);
        hif.deckAck  = 1'b0;
        hif.deckCard = 4'd0;
        @(negedge clk);
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if (hif.totalValue !== e.tot) begin
            bad++;
            $display("FAIL total rank=%0d: got %0d, required %0d", rank, hif.totalValue, e.tot);
        end
        total++;
        if (hif.cardCount !== e.cnt) begin
            bad++;
            $display("FAIL count rank=%0d: got %0d, required %0d", rank, hif.cardCount, e.cnt);
        end
        total++;
        if (hif.badCard !== e.bad) begin
            bad++;
            $display("FAIL badCard rank=%0d: got %0b, required %0b", rank, hif.badCard, e.bad);
        end
    endtask

    task automatic check_flags(input string name, input logic e_fin, input logic e_bust,
                               input logic e_bj);
        total++;
        if ({hif.finish, hif.bust, hif.blackjack} !== {e_fin, e_bust, e_bj}) begin
            bad++;
            $display("FAIL %s flags fin/bust/bj: got %b%b%b, required %b%b%b", name,
                     hif.finish, hif.bust, hif.blackjack, e_fin, e_bust, e_bj);
        end
    endtask

    task automatic expect_no_req(input string name, input int cycles);
        int seen_req;
        seen_req = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (hif.deckReq === 1'b1) seen_req++;
        end
        total++;
        if (seen_req != 0) begin
            bad++;
            $display("FAIL %s no_req: deckReq high %0d cycles, required 0", name, seen_req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        total++;
        if ({hif.deckReq, hif.totalValue, hif.cardCount, hif.finish, hif.bust,
             hif.blackjack, hif.badCard} !== 13'd0) begin
            bad++;
            $display("FAIL reset_init: outputs not all zero (total=%0d cnt=%0d req=%0b)",
                     hif.totalValue, hif.cardCount, hif.deckReq);
        end
        @(negedge clk);
        rst = 1'b0;
        hif.cardReady = 1'b1;
        deal(4'd13, 1, 5'd10, 3'd1, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (hif.deckReq !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_req: deckReq got %0b, required 1", hif.deckReq);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (hif.deckReq !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_req deckReq: got %0b, required 0", hif.deckReq);
        end
        total++;
        if ({hif.totalValue, hif.cardCount, hif.finish, hif.bust, hif.blackjack,
             hif.badCard} !== 12'd0) begin
            bad++;
            $display("FAIL reset_mid_req outputs: total=%0d cnt=%0d, required 0 0",
                     hif.totalValue, hif.cardCount);
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_king_seven();
        new_game();
        hif.cardReady = 1'b1;
        deal(4'd13, 2, 5'd10, 3'd1, 1'b0, 1'b0);
        deal(4'd7,  2, 5'd17, 3'd2, 1'b0, 1'b0);
        check_flags("k7", 1'b1, 1'b0, 1'b0);
        expect_no_req("k7", 5);
    endtask

    task automatic test_blackjack();
        new_game();
        hif.cardReady = 1'b1;
        deal(4'd1,  0, 5'd11, 3'd1, 1'b0, 1'b0);
        deal(4'd13, 1, 5'd21, 3'd2, 1'b0, 1'b0);
        check_flags("ak", 1'b1, 1'b0, 1'b1);
        expect_no_req("ak", 6);
    endtask

    task automatic test_soft_ace();
        new_game();
        hif.cardReady = 1'b1;
        deal(4'd1, 1, 5'd11, 3'd1, 1'b0, 1'b0);
        deal(4'd5, 0, 5'd16, 3'd2, 1'b0, 1'b0);
        deal(4'd9, 3, 5'd15, 3'd3, 1'b0, 1'b0);
        check_flags("a59", 1'b0, 1'b0, 1'b0);
        deal(4'd1, 1, 5'd16, 3'd4, 1'b0, 1'b0);
        deal(4'd9, 0, 5'd25, 3'd5, 1'b0, 1'b0);
        check_flags("a59a9", 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_stand();
        new_game();
        hif.cardReady = 1'b1;
        deal(4'd10, 1, 5'd10, 3'd1, 1'b0, 1'b1);
        hif.cardReady = 1'b1;
        deal(4'd2,  0, 5'd12, 3'd2, 1'b0, 1'b1);
        hif.stand     = 1'b1;
        hif.cardReady = 1'b1;
        expect_no_req("stand", 6);
        check_flags("stand", 1'b1, 1'b0, 1'b0);
        total++;
        if (hif.totalValue !== 5'd12) begin
            bad++;
            $display("FAIL stand total: got %0d, required 12", hif.totalValue);
        end
        clear_inputs();
    endtask

    task automatic test_bad_card();
        new_game();
        hif.cardReady = 1'b1;
        deal(4'd4,  0, 5'd4, 3'd1, 1'b0, 1'b0);
        deal(4'd14, 1, 5'd4, 3'd1, 1'b1, 1'b0);
        deal(4'd3,  0, 5'd7, 3'd2, 1'b0, 1'b0);
        deal(4'd0,  0, 5'd7, 3'd2, 1'b1, 1'b0);
        deal(4'd12, 2, 5'd17, 3'd3, 1'b0, 1'b0);
        check_flags("bad", 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_inputs();
        test_reset();
        test_king_seven();
        test_blackjack();
        test_soft_ace();
        test_stand();
        test_bad_card();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left: %0d entries, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
